// File: rtl/rr_arbiter8.sv
// rr_arbiter8 -- eight-requester round-robin arbiter with bounded hold time.
//
// A single winner is chosen in IDLE by scanning req starting at the priority
// pointer. The grant is held while the winner keeps requesting, for at most
// HOLD_MAX cycles. It is then force-released and preempt pulses. Every
// release passes through exactly one IDLE cycle with grant=0
// (break-before-make). The pointer then moves to the slot after the winner.
//
// Ports:
//   sys_clk      rising-edge clock
//   sys_rst_n    asynchronous active-low reset
//   req[7:0]     request vector, bit i = requester i
//   grant[7:0]   registered one-hot grant, zero when idle
//   grant_idx    binary index of the current/last winner (kept in IDLE)
//   grant_valid  high while a grant is held
//   preempt      one-cycle pulse on a HOLD_MAX forced release
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16   // legal 2..256
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       preempt
);

  localparam int NUM_LANES = 8;
  localparam int CW        = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [CW-1:0] cnt;

  // Request vector rotated so that bit 0 is the requester at ptr.
  // The scan then becomes a plain lowest-set-bit search.
  logic [NUM_LANES-1:0] rot;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_rot
    assign rot[i] = req[ptr + 3'(i)];
  end

  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic       found;

  always_comb begin
    win_off = 3'd0;
    found   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!found && rot[i]) begin
        win_off = i[2:0];
        found   = 1'b1;
      end
    end
    win_idx = ptr + win_off;   // 3-bit add wraps mod 8
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      ptr         <= 3'd0;
      cnt         <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_idx   <= win_idx;
            grant       <= 8'(1) << win_idx;
            grant_valid <= 1'b1;
            cnt         <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // A drop by the winner takes priority over the hold limit.
          // A drop on the last allowed cycle is therefore a normal
          // release, and preempt stays low.
          if (!req[grant_idx] || cnt == CNT_LAST) begin
            grant       <= 8'h00;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 3'd1;
            preempt     <= req[grant_idx];
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (HOLD_MAX=4).
// The stimulus drives req on the falling edge. It pushes the output that is
// expected after the next rising edge. The monitor pops one entry at 1 ns
// after each rising edge and compares it against the DUT.
module tb_rr_arbiter8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_step = 0;

  typedef struct {
    int         id;
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
    logic       p;
  } exp_t;

  exp_t q[$];

  rr_arbiter8 #(.HOLD_MAX(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .preempt    (preempt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic cmp(input string name, input logic [7:0] g, input logic [2:0] idx,
                     input logic v, input logic p);
    n_chk++;
    if (grant === g && grant_idx === idx && grant_valid === v && preempt === p)
      n_pass++;
    else
      $display("FAIL %s: got grant=%h idx=%0d valid=%b preempt=%b, want grant=%h idx=%0d valid=%b preempt=%b",
               name, grant, grant_idx, grant_valid, preempt, g, idx, v, p);
  endtask

  // Monitor: one expectation is consumed per clock cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp($sformatf("step%0d", e.id), e.g, e.idx, e.v, e.p);
      end
    end
  end

  task automatic step(input logic [7:0] r, input logic [7:0] g, input int idx,
                      input logic v, input logic p);
    exp_t e;
    @(negedge sys_clk);
    req = r;
    e.id = n_step++; e.g = g; e.idx = 3'(idx); e.v = v; e.p = p;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge sys_clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000ns");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    #1 sys_rst_n = 1'b0;
    #1 cmp("por", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 0, 0, 0);

    // Single request: requester 4 for 3 cycles, ptr -> 5
    step(8'h10, 8'h10, 4, 1, 0);
    step(8'h10, 8'h10, 4, 1, 0);
    step(8'h10, 8'h10, 4, 1, 0);
    step(8'h00, 8'h00, 4, 0, 0);
    step(8'h00, 8'h00, 4, 0, 0);
    // Requester 5 wins from ptr=5 even though lower bits are set
    step(8'h21, 8'h20, 5, 1, 0);
    step(8'h00, 8'h00, 5, 0, 0);
    // Serve requester 7 so that ptr wraps to 0
    step(8'h80, 8'h80, 7, 1, 0);
    step(8'h00, 8'h00, 7, 0, 0);

    // Fairness: all requesting, each winner drops for one cycle
    for (int i = 0; i < 9; i++) begin
      int k;
      k = i % 8;
      step(8'hFF, 8'(1) << k, k, 1, 0);
      step(8'hFF & ~(8'(1) << k), 8'h00, k, 0, 0);
    end
    // ptr=1 now; serve 7 to bring ptr back to 0
    step(8'h80, 8'h80, 7, 1, 0);
    step(8'h00, 8'h00, 7, 0, 0);

    // Timeout with req=05 held
    for (int i = 0; i < 4; i++) step(8'h05, 8'h01, 0, 1, 0);
    step(8'h05, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(8'h05, 8'h04, 2, 1, 0);
    step(8'h05, 8'h00, 2, 0, 1);
    step(8'h05, 8'h01, 0, 1, 0);
    step(8'h00, 8'h00, 0, 0, 0);

    // Wrap-around: serve 6 (ptr -> 7), then req=41
    step(8'h40, 8'h40, 6, 1, 0);
    step(8'h01, 8'h00, 6, 0, 0);
    step(8'h41, 8'h01, 0, 1, 0);
    step(8'h40, 8'h00, 0, 0, 0);
    step(8'h41, 8'h40, 6, 1, 0);
    step(8'h00, 8'h00, 6, 0, 0);

    // Drop on the 4th grant cycle: normal release, no preempt
    for (int i = 0; i < 4; i++) step(8'h04, 8'h04, 2, 1, 0);
    step(8'h00, 8'h00, 2, 0, 0);
    step(8'h00, 8'h00, 2, 0, 0);

    // Reset mid-grant (ptr=3 before reset)
    step(8'h08, 8'h08, 3, 1, 0);
    step(8'h08, 8'h08, 3, 1, 0);
    drain();
    sys_rst_n = 1'b0;
    #1 cmp("rst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge sys_clk); req = 8'h00; sys_rst_n = 1'b1;
    #1 cmp("rst_release", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(8'h00, 8'h00, 0, 0, 0);
    // ptr must be 0 again: with req=81, requester 0 wins, not requester 7
    step(8'h81, 8'h01, 0, 1, 0);
    step(8'h00, 8'h00, 0, 0, 0);

    drain();
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one resource among requesters and drives a one-hot 8-bit grant, the same one-hot encoding our 3-to-8 decoder produces from a 3-bit index. Sits between up to eight request sources and the shared resource. Issues at most one grant at a time, holds it while the winner keeps requesting, and force-releases after a bounded hold time so no requester starves.

## Interface
- HOLD_MAX, 16: maximum consecutive cycles a grant is held; legal range 2..256.
- sys_clk  input  1  clock; all state updates on the rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i is requester i.
- grant  output  8  one-hot grant, registered; all zeros when nothing is granted.
- grant_idx  output  3  binary index of the granted requester; grant equals the decoded grant_idx whenever grant_valid=1.
- grant_valid  output  1  high while a grant is held.
- preempt  output  1  one-cycle pulse when a grant is force-released by the HOLD_MAX limit.

## Operation
- Reset values (asynchronous, immediate): state=IDLE, grant=8'h00, grant_idx=3'd0, grant_valid=0, preempt=0, priority pointer ptr=3'd0, hold counter cnt=0.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req, scanning ptr, ptr+1, ... ptr+7, all mod 8.
  - Register grant_idx=winner, grant=1<<winner, grant_valid=1, cnt=0, and go to GRANT.
- GRANT: each cycle, evaluate the release conditions in this priority order.
  - If req[grant_idx]==0: normal release. Next cycle grant=0 and grant_valid=0, ptr=grant_idx+1 mod 8, state=IDLE, preempt=0.
  - Else if cnt==HOLD_MAX-1: forced release. Same as normal release, plus preempt=1 for that one cycle.
  - Else: cnt=cnt+1, and grant is unchanged.
- grant_idx keeps its last value in IDLE. Only grant_valid and grant are cleared.
- Requests from other requesters are ignored during GRANT. Changes to them take effect only at the next IDLE evaluation.
- ptr wraps from 7 to 0.
- cnt width is clog2(HOLD_MAX). cnt never exceeds HOLD_MAX-1.
- Break-before-make: every release is followed by exactly one IDLE cycle with grant=0, even when other requests are pending.

## Timing
- Request to grant: a nonzero req sampled in IDLE at edge N gives a valid grant after edge N (visible in cycle N+1).
- Maximum hold: a continuously requesting winner holds grant for exactly HOLD_MAX cycles.
- Release: if req[grant_idx] is low at edge M, grant is 0 after edge M. The next arbitration is evaluated at edge M+1, so a new grant appears after edge M+1.
- Simultaneous events: if the requester drops req in the same cycle that cnt==HOLD_MAX-1, this counts as a normal release and preempt stays 0.
- Reset mid-grant: reset clears everything asynchronously, including ptr. The first grant after reset starts scanning from requester 0.

## Test plan
- Reset and idle: assert sys_rst_n=0 mid-grant, then release reset with req=0. Required: grant=00, grant_valid=0, preempt=0, grant_idx=0 immediately and for 10 cycles after release.
- Single request: set req=8'h10 for 3 cycles, then 0. Required: grant=8'h10 and grant_idx=4 for 3 cycles starting one cycle after req rises; grant=00 one cycle after req falls; ptr=5.
- Round-robin fairness: hold req=8'hFF and have each winner drop its bit for one cycle after a 1-cycle grant, then reassert. Required grant order: 01, 02, 04, ... 80, 01, with one idle cycle between grants.
- Timeout: HOLD_MAX=4, req=8'h05 held constant. Required: grant=01 for exactly 4 cycles, preempt=1 on the first idle cycle, then grant=04 for 4 cycles, then 01 again.
- Wrap-around: with ptr=7 (requester 6 just served) and req=8'h41. Required: requester 0 wins. After requester 0 releases, requester 6 wins next.
- Simultaneous drop at limit: HOLD_MAX=4, requester 2 drops req on its 4th grant cycle. Required: grant clears the next cycle and preempt stays 0.
